// File: rtl/nn_pkg.sv
// rtl/nn_pkg.sv - shared constants, node state enum and finalize helper for the MNIST datapath
package nn_pkg;

    localparam int NN_DATA_W = 16;
    localparam int NN_ACC_W  = 40;
    localparam int NN_FRAC   = 8;
    localparam int NN_LANES  = 10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_BIAS,
        ST_ACCUM,
        ST_FINAL,
        ST_DONE
    } node_state_e;

    // Rescale Q16.16 accumulator to Q8.8 (floor), clamp to the DATA_W range, optional ReLU.
    function automatic logic [NN_DATA_W-1:0] nn_sat_relu(
        input logic [NN_ACC_W-1:0] acc,
        input logic                relu
    );
        logic signed [NN_ACC_W-1:0] r;
        logic signed [NN_ACC_W-1:0] sat_max;
        logic signed [NN_ACC_W-1:0] sat_min;
        logic        [NN_DATA_W-1:0] res;
        sat_max = {{(NN_ACC_W-NN_DATA_W+1){1'b0}}, {(NN_DATA_W-1){1'b1}}};
        sat_min = ~sat_max;
        r       = $signed(acc) >>> NN_FRAC;
        if (relu && r[NN_ACC_W-1]) begin
            res = '0;
        end else if (r > sat_max) begin
            res = sat_max[NN_DATA_W-1:0];
        end else if (r < sat_min) begin
            res = sat_min[NN_DATA_W-1:0];
        end else begin
            res = r[NN_DATA_W-1:0];
        end
        return res;
    endfunction

endpackage

// File: rtl/mac_lane.sv
// rtl/mac_lane.sv - one neuron lane: bias load, signed multiply-accumulate, finalize value
module mac_lane
    import nn_pkg::*;
#(
    parameter int DATA_W = NN_DATA_W,
    parameter int ACC_W  = NN_ACC_W,
    parameter int FRAC   = NN_FRAC
) (
    input  logic              clock,
    input  logic              rst,
    input  logic              clr_load_bias,
    input  logic              en,
    input  logic [DATA_W-1:0] x,
    input  logic [DATA_W-1:0] w,
    input  logic [DATA_W-1:0] b,
    input  logic              finalize,
    input  logic              relu,
    output logic [DATA_W-1:0] result
);

    logic [ACC_W-1:0]          acc_q;
    logic [ACC_W-1:0]          acc_d;
    logic signed [2*DATA_W-1:0] xs;
    logic signed [2*DATA_W-1:0] ws;
    logic signed [2*DATA_W-1:0] prod;

    always_comb begin
        xs    = {{DATA_W{x[DATA_W-1]}}, x};
        ws    = {{DATA_W{w[DATA_W-1]}}, w};
        prod  = xs * ws;
        acc_d = acc_q;
        if (clr_load_bias) begin
            acc_d = {{(ACC_W-DATA_W-FRAC){b[DATA_W-1]}}, b, {FRAC{1'b0}}};
        end else if (en) begin
            // Wraps silently at ACC_W; no accumulator saturation.
            acc_d = acc_q + {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};
        end
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign result = finalize ? nn_sat_relu(acc_q, relu) : '0;

endmodule

// File: rtl/neuron_node_array.sv
// rtl/neuron_node_array.sv - ten-lane MAC node array with segment FSM and registered result readout
module neuron_node_array
    import nn_pkg::*;
#(
    parameter int DATA_W = NN_DATA_W,
    parameter int ACC_W  = NN_ACC_W,
    parameter int FRAC   = NN_FRAC,
    parameter int LANES  = NN_LANES
) (
    input  logic                    clock,
    input  logic                    rst,
    input  logic                    head_c2node,
    input  logic [9:0]              seg_len,
    input  logic                    relu_en,
    input  logic                    valid_m2node,
    input  logic [DATA_W-1:0]       x_data,
    input  logic [LANES*DATA_W-1:0] w_data,
    input  logic [LANES*DATA_W-1:0] b_data,
    input  logic [3:0]              data_select_c2node,
    output logic                    done_flag_node2c,
    output logic [DATA_W-1:0]       data_out,
    output logic                    busy
);

    node_state_e       state_q, state_d;
    logic [9:0]        cnt_q, cnt_d, cnt_inc;
    logic [9:0]        seg_len_q, seg_len_d;
    logic              relu_q, relu_d;
    logic              clr_load_bias, acc_en, finalize;
    logic [DATA_W-1:0] lane_res [LANES];
    logic [DATA_W-1:0] res_q [LANES];
    logic [DATA_W-1:0] res_d [LANES];
    logic [DATA_W-1:0] data_out_q, data_out_d;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        mac_lane #(.DATA_W(DATA_W), .ACC_W(ACC_W), .FRAC(FRAC)) u_lane (
            .clock         (clock),
            .rst           (rst),
            .clr_load_bias (clr_load_bias),
            .en            (acc_en),
            .x             (x_data),
            .w             (w_data[i*DATA_W +: DATA_W]),
            .b             (b_data[i*DATA_W +: DATA_W]),
            .finalize      (finalize),
            .relu          (relu_q),
            .result        (lane_res[i])
        );
    end

    // A head pulse restarts the segment from any state and drops a coincident beat.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        seg_len_d     = seg_len_q;
        relu_d        = relu_q;
        clr_load_bias = 1'b0;
        acc_en        = 1'b0;
        finalize      = 1'b0;
        cnt_inc       = cnt_q + 10'd1;
        if (head_c2node) begin
            state_d   = ST_BIAS;
            cnt_d     = '0;
            seg_len_d = seg_len;
            relu_d    = relu_en;
        end else begin
            case (state_q)
                ST_BIAS: begin
                    clr_load_bias = 1'b1;
                    state_d       = (seg_len_q == 10'd0) ? ST_FINAL : ST_ACCUM;
                end
                ST_ACCUM: begin
                    if (valid_m2node) begin
                        acc_en = 1'b1;
                        cnt_d  = cnt_inc;
                        if (cnt_inc == seg_len_q) begin
                            state_d = ST_FINAL;
                        end
                    end
                end
                ST_FINAL: begin
                    finalize = 1'b1;
                    state_d  = ST_DONE;
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            res_d[i] = finalize ? lane_res[i] : res_q[i];
        end
        data_out_d = '0;
        if (int'(data_select_c2node) < LANES) begin
            data_out_d = res_q[data_select_c2node];
        end
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            seg_len_q  <= '0;
            relu_q     <= 1'b0;
            data_out_q <= '0;
            for (int i = 0; i < LANES; i++) begin
                res_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            seg_len_q  <= seg_len_d;
            relu_q     <= relu_d;
            data_out_q <= data_out_d;
            for (int i = 0; i < LANES; i++) begin
                res_q[i] <= res_d[i];
            end
        end
    end

    assign done_flag_node2c = (state_q == ST_DONE);
    assign busy             = (state_q != ST_IDLE) && (state_q != ST_DONE);
    assign data_out         = data_out_q;

endmodule
